mem_sram_adapter: RTL and testbench
===================================

# mem_sram_adapter

Data-side access adapter between the MEM pipeline stage and the data sram-like port of the CPU-to-AXI bridge. It takes one load/store per handshake from MEM and issues one sram-like data transaction: size, byte-lane strobes and replicated write data. It waits for the address and data acknowledgements, then returns an aligned, sign- or zero-extended load result or a store completion to WB. Misaligned accesses raise an address-error response without touching the bus. A pipeline flush cancels the transaction cleanly.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  reset, synchronous, active-low
- req_valid  in  1  MEM presents an access
- req_ready  out  1  adapter accepts access (high only in IDLE)
- req_wr  in  1  1 = store, 0 = load
- req_width  in  2  0 byte, 1 half, 2 word (3 treated as word)
- req_unsigned  in  1  zero-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- data_req  out  1  sram-like request
- data_wr  out  1  sram-like write
- data_size  out  2  equals latched req_width
- data_addr  out  32  latched req_addr
- data_wdata  out  32  replicated store data
- data_wstrb  out  4  byte-lane strobes
- data_rdata  in  32  read data, valid with data_data_ok
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response returned
- rsp_valid  out  1  result to WB
- rsp_ready  in  1  WB accepts result
- rsp_rdata  out  32  extended load data (0 for stores)
- rsp_exc  out  1  address error
- rsp_badvaddr  out  32  faulting address (0 when no error)
- flush  in  1  cancel in-flight access, drop pending result

## Operation
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE: req_ready=1. On req_valid, latch wr, width, unsigned, addr, and wdata.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0): go to RESP with rsp_exc=1 and rsp_badvaddr=addr. No bus request.
  - Otherwise go to REQ.
- REQ: data_req=1. Outputs are stable until data_addr_ok.
  - addr_ok without data_ok: go to WAIT.
  - addr_ok and data_ok in the same cycle: complete, go to RESP.
- WAIT: data_req=0. On data_data_ok, capture the result and go to RESP.
- RESP: rsp_valid=1, outputs held. On rsp_ready, go to IDLE.
- Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: shifted = data_rdata >> (8*addr[1:0]).
  - byte: sign- or zero-extend shifted[7:0].
  - half: sign- or zero-extend shifted[15:0].
  - word: data_rdata.
- Flush has priority over every other transition.
  - In IDLE or RESP: go to IDLE, no response is produced.
  - In REQ: data_req stays high until addr_ok (sram-like rule), then go to DRAIN. If data_ok arrives in the same cycle as addr_ok, go to IDLE.
  - In WAIT: go to DRAIN. If data_ok arrives in the same cycle, go to IDLE.
  - In DRAIN: await data_data_ok, discard the data, go to IDLE. Further flush has no effect.
- At most one outstanding transaction. req_ready=0 in every state except IDLE.

## Timing
- Reset values: all state and outputs 0; req_ready=1 (state IDLE).
- Accept in cycle 0 gives data_req=1 from cycle 1 (registered).
- addr_ok in cycle k gives data_req=0 in cycle k+1.
- data_ok in cycle m gives rsp_valid=1 in cycle m+1 with registered rsp_rdata.
- Minimum load latency is accept→rsp_valid = 2 cycles (addr_ok and data_ok in cycle 1).
- Misaligned access: rsp_valid in cycle 1. data_req never asserts.
- rsp_valid held until rsp_ready. Next accept is possible the cycle after rsp_valid && rsp_ready.
- data_data_ok in IDLE or RESP is ignored.
- Reset mid-transaction returns to IDLE next cycle. No drain is performed.

## Test plan
- Word load addr 0x100, addr_ok cycle 2, data_ok cycle 4, rdata 0x80FF1234 → data_req cycles 1-2, size 2, wstrb 4'b1111; rsp_rdata 0x80FF1234 at cycle 5.
- Byte load addr 0x103, rdata 0x80FF1234, signed then unsigned → 0xFFFFFF80 then 0x00000080. Half load addr 0x102 signed → 0xFFFF80FF.
- Byte store addr 0x201, wdata 0x000000AB → data_wr=1, size 0, wstrb 4'b0010, data_wdata 0xABABABAB; store response rsp_rdata 0.
- Half load addr 0x301 → rsp_exc=1, rsp_badvaddr 0x301 at cycle 1; data_req stays 0 throughout.
- Flush during REQ before addr_ok → data_req held until addr_ok; the later data_ok is swallowed; rsp_valid never asserts; req_ready returns 1 the cycle after data_ok.
- rsp_ready held low 3 cycles → rsp outputs stable and req_ready=0; same-cycle addr_ok+data_ok path gives rsp_valid at cycle 2.

Source files
------------

// File: rtl/mem_sram_adapter.sv
// MEM-stage data access adapter onto the sram-like data port of the AXI bridge.
// One load/store at a time: lane steering, load extension, misalignment traps and flush draining.
module mem_sram_adapter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic [31:0] rsp_badvaddr,
  input  logic        flush
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        wr_q, uns_q, exc_q, flushed_q, flushed_nxt;
  logic [1:0]  width_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        accept, capture, misaligned;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] a);
    case (width)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] width, input logic [1:0] a);
    case (width)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] width, input logic [31:0] d);
    case (width)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] width, input logic uns,
                                               input logic [1:0] a, input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {a, 3'b000};
    case (width)
      2'd0:    return {{24{~uns & shifted[7]}}, shifted[7:0]};
      2'd1:    return {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign misaligned = is_misaligned(req_width, req_addr[1:0]);

  // A flush seen in REQ before addr_ok is remembered in flushed_q so the
  // request can stay on the bus until it is accepted, then be drained.
  always_comb begin
    state_nxt   = state;
    flushed_nxt = flushed_q;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && req_valid) begin
          accept    = 1'b1;
          state_nxt = misaligned ? RESP : REQ;
        end
      end
      REQ: begin
        if (data_addr_ok) begin
          flushed_nxt = 1'b0;
          if (flush || flushed_q) begin
            state_nxt = data_data_ok ? IDLE : DRAIN;
          end else if (data_data_ok) begin
            capture   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end else if (flush) begin
          flushed_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          state_nxt = data_data_ok ? IDLE : DRAIN;
        end else if (data_data_ok) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (flush || rsp_ready) state_nxt = IDLE;
      end
      DRAIN: begin
        if (data_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      flushed_q <= 1'b0;
      wr_q      <= 1'b0;
      width_q   <= 2'd0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      exc_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      flushed_q <= flushed_nxt;
      if (accept) begin
        wr_q    <= req_wr;
        width_q <= req_width;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        exc_q   <= misaligned;
        rdata_q <= '0;
      end else if (capture) begin
        rdata_q <= wr_q ? 32'd0 : load_extract(width_q, uns_q, addr_q[1:0], data_rdata);
      end
    end
  end

  assign req_ready    = (state == IDLE);
  assign data_req     = (state == REQ);
  assign data_wr      = wr_q;
  assign data_size    = width_q;
  assign data_addr    = addr_q;
  assign data_wdata   = lane_wdata(width_q, wdata_q);
  assign data_wstrb   = data_req ? lane_strobe(width_q, addr_q[1:0]) : 4'b0000;
  assign rsp_valid    = (state == RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_exc      = exc_q;
  assign rsp_badvaddr = exc_q ? addr_q : 32'd0;

endmodule

// File: tb/tb_mem_sram_adapter.sv
// Directed bench for mem_sram_adapter: vector table of single accesses plus
// hand-written flush, stall and reset sequences.
module tb_mem_sram_adapter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_wr, req_unsigned;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic        rsp_valid, rsp_ready, rsp_exc;
  logic [31:0] rsp_rdata, rsp_badvaddr;
  logic        flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_sram_adapter dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_width(req_width), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_exc(rsp_exc), .rsp_badvaddr(rsp_badvaddr), .flush(flush)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ak;
    int          dk;
    logic [3:0]  strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic wr, input logic [1:0] width, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_wr = wr; req_width = width; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   rc;
    v  = vecs[i];
    rc = v.exc ? 1 : v.dk + 1;
    chk($sformatf("v%0d_req_ready_c0", i), req_ready, 1);
    accept(v.wr, v.width, v.uns, v.addr, v.wdata);
    for (int c = 1; c <= rc; c++) begin
      chk($sformatf("v%0d_data_req_c%0d", i, c), data_req, (c <= v.ak) ? 1 : 0);
      if (c == 1 && !v.exc) begin
        chk($sformatf("v%0d_data_wr", i), data_wr, v.wr);
        chk($sformatf("v%0d_data_size", i), data_size, v.width);
        chk($sformatf("v%0d_data_addr", i), data_addr, v.addr);
        chk($sformatf("v%0d_data_wstrb", i), data_wstrb, v.strb);
        chk($sformatf("v%0d_data_wdata", i), data_wdata, v.exp_wdata);
      end
      if (c == rc) begin
        chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
        chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_rsp_exc", i), rsp_exc, v.exc);
        chk($sformatf("v%0d_rsp_badvaddr", i), rsp_badvaddr, v.exc ? v.addr : 32'd0);
        rsp_ready = 1'b1;
      end else begin
        chk($sformatf("v%0d_rsp_valid_c%0d", i, c), rsp_valid, 0);
      end
      data_addr_ok = (c == v.ak);
      data_data_ok = (c == v.dk);
      data_rdata   = (c == v.dk) ? v.rdata : 32'hDEADBEEF;
      step();
    end
    rsp_ready = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk($sformatf("v%0d_req_ready_after", i), req_ready, 1);
    chk($sformatf("v%0d_rsp_valid_after", i), rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             wr    w     uns   addr          wdata         rdata        ak dk strb     exp_wdata     exp_rdata     exc
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,        32'h80FF1234, 2, 4, 4'b1111, 32'h0,        32'h80FF1234, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h00000103, 32'h0,        32'h80FF1234, 1, 2, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h00000103, 32'h0,        32'h80FF1234, 1, 2, 4'b1000, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h00000102, 32'h0,        32'h80FF1234, 1, 3, 4'b1100, 32'h0,        32'hFFFF80FF, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h00000201, 32'h000000AB, 32'h55555555, 1, 3, 4'b0010, 32'hABABABAB, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h00000301, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h00000104, 32'h0,        32'h12345678, 1, 1, 4'b1111, 32'h0,        32'h12345678, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h00000206, 32'h1234CDEF, 32'h0,        2, 2, 4'b1100, 32'hCDEFCDEF, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h00000108, 32'h0,        32'hA5A5C3C3, 1, 2, 4'b1111, 32'h0,        32'hA5A5C3C3, 1'b0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000010A, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h00000100, 32'h0,        32'h1234F00D, 1, 2, 4'b0011, 32'h0,        32'h0000F00D, 1'b0};

    resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_width = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; data_rdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    rsp_ready = 1'b0; flush = 1'b0;
    step(); step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_data_req", data_req, 0);
    chk("rst_data_wstrb", data_wstrb, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_exc", rsp_exc, 0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 11; i++) run_vec(i);

    // Flush during REQ before addr_ok: request held until accepted, then drained.
    accept(1'b0, 2'd2, 1'b0, 32'h00000400, 32'h0);
    flush = 1'b1;
    chk("fr_c1_data_req", data_req, 1);
    step(); flush = 1'b0;
    chk("fr_c2_data_req", data_req, 1);
    step(); data_addr_ok = 1'b1;
    chk("fr_c3_data_req", data_req, 1);
    step(); data_addr_ok = 1'b0;
    chk("fr_c4_data_req", data_req, 0);
    chk("fr_c4_req_ready", req_ready, 0);
    chk("fr_c4_rsp_valid", rsp_valid, 0);
    step(); data_data_ok = 1'b1; data_rdata = 32'h11112222;
    chk("fr_c5_req_ready", req_ready, 0);
    step(); data_data_ok = 1'b0;
    chk("fr_c6_req_ready", req_ready, 1);
    chk("fr_c6_rsp_valid", rsp_valid, 0);
    step();
    chk("fr_c7_rsp_valid", rsp_valid, 0);

    // Same-cycle addr_ok+data_ok with a 3-cycle rsp_ready stall; stray data_ok ignored.
    accept(1'b0, 2'd2, 1'b0, 32'h0000010C, 32'h0);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    step(); data_addr_ok = 1'b0; data_data_ok = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("st_c%0d_rsp_valid", c), rsp_valid, 1);
      chk($sformatf("st_c%0d_rsp_rdata", c), rsp_rdata, 32'hCAFEF00D);
      chk($sformatf("st_c%0d_req_ready", c), req_ready, 0);
      chk($sformatf("st_c%0d_data_req", c), data_req, 0);
      data_data_ok = 1'b1; data_rdata = 32'h0BADBAD0;
      step();
      data_data_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    chk("st_c5_rsp_valid", rsp_valid, 1);
    chk("st_c5_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    step(); rsp_ready = 1'b0;
    chk("st_c6_req_ready", req_ready, 1);
    chk("st_c6_rsp_valid", rsp_valid, 0);

    // Flush in RESP drops a pending misalignment response.
    accept(1'b0, 2'd2, 1'b0, 32'h00000503, 32'h0);
    chk("fp_c1_rsp_valid", rsp_valid, 1);
    chk("fp_c1_rsp_badvaddr", rsp_badvaddr, 32'h00000503);
    flush = 1'b1;
    step(); flush = 1'b0;
    chk("fp_c2_rsp_valid", rsp_valid, 0);
    chk("fp_c2_req_ready", req_ready, 1);

    // Flush in WAIT together with data_ok goes straight back to IDLE.
    accept(1'b0, 2'd2, 1'b0, 32'h00000600, 32'h0);
    data_addr_ok = 1'b1;
    step(); data_addr_ok = 1'b0;
    chk("fw_c2_data_req", data_req, 0);
    flush = 1'b1; data_data_ok = 1'b1;
    step(); flush = 1'b0; data_data_ok = 1'b0;
    chk("fw_c3_req_ready", req_ready, 1);
    chk("fw_c3_rsp_valid", rsp_valid, 0);

    // Reset while waiting for data returns to IDLE on the next cycle.
    accept(1'b0, 2'd2, 1'b0, 32'h00000700, 32'h0);
    data_addr_ok = 1'b1;
    step(); data_addr_ok = 1'b0;
    chk("rw_c2_req_ready", req_ready, 0);
    resetn = 1'b0;
    step(); resetn = 1'b1;
    chk("rw_c3_req_ready", req_ready, 1);
    chk("rw_c3_data_addr", data_addr, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
